regfile_wb_arbiter: RTL and testbench

//  Shares reg_file's single write port (A3/WD3/WEN) between two writeback requesters: 0 = ALU/exec, 1 = memory/load.

---
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter in front of reg_file: two writeback requesters, each with
// a one-entry holding register, drained oldest-first. Pending entries are
// also searched for the decode stage's two read addresses (forwarding).
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]      A3,
  output logic [DATA_W-1:0]      WD3,
  output logic                   WEN,
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2
);

  typedef enum logic {SLOT0 = 1'b0, SLOT1 = 1'b1} slot_e;

  logic [1:0]             held_q, held_d;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0][DATA_W-1:0] data_q;
  slot_e                  older_q, older_d;
  slot_e                  rr_q, rr_d;
  logic                   run_q;

  logic [1:0]             grant;
  logic [1:0]             accept;
  logic [1:0]             load;

  logic [1:0][ADDR_W-1:0] rd_a;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_data;

  // Grant from registered state only: the sole held entry, or the older one.
  always_comb begin
    grant = '0;
    if (held_q[0] && (!held_q[1] || older_q == SLOT0)) grant[0] = 1'b1;
    if (held_q[1] && (!held_q[0] || older_q == SLOT1)) grant[1] = 1'b1;
  end

  // Handshake and next-state for holding entries, age and round-robin pointers.
  always_comb begin
    req_ready = {2{run_q}} & (~held_q | grant);
    accept    = req_valid & req_ready;
    for (int unsigned i = 0; i < 2; i++) begin
      // Writes to $0 complete the handshake but are dropped here.
      load[i] = accept[i] && (req_addr[i] != '0);
    end
    held_d  = load | (held_q & ~grant);
    older_d = older_q;
    rr_d    = rr_q;
    if (load[0] && load[1]) begin
      older_d = rr_q;
      rr_d    = (rr_q == SLOT0) ? SLOT1 : SLOT0;
    end else if (load[0] && held_d[1]) begin
      older_d = SLOT1;
    end else if (load[1] && held_d[0]) begin
      older_d = SLOT0;
    end
  end

  // Holding entries and pointers; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      older_q <= SLOT0;
      rr_q    <= SLOT0;
      run_q   <= 1'b0;
    end else begin
      held_q  <= held_d;
      older_q <= older_d;
      rr_q    <= rr_d;
      run_q   <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (load[i]) begin
          addr_q[i] <= req_addr[i];
          data_q[i] <= req_data[i];
        end
      end
    end
  end

  // reg_file write port decoded from the granted entry.
  always_comb begin
    WEN = |grant;
    A3  = '0;
    WD3 = '0;
    if (grant[0]) begin
      A3  = addr_q[0];
      WD3 = data_q[0];
    end else if (grant[1]) begin
      A3  = addr_q[1];
      WD3 = data_q[1];
    end
  end

  // Pending-write lookup per read port; when both entries match, the younger wins.
  always_comb begin
    logic [1:0] m;
    m        = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    rd_a     = {rd_addr2, rd_addr1};
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned e = 0; e < 2; e++) begin
        m[e] = held_q[e] && (addr_q[e] == rd_a[p]) && (rd_a[p] != '0);
      end
      fwd_hit[p] = |m;
      if (&m)        fwd_data[p] = (older_q == SLOT0) ? data_q[1] : data_q[0];
      else if (m[0]) fwd_data[p] = data_q[0];
      else if (m[1]) fwd_data[p] = data_q[1];
    end
  end

  assign fwd_hit1  = fwd_hit[0];
  assign fwd_hit2  = fwd_hit[1];
  assign fwd_data1 = fwd_data[0];
  assign fwd_data2 = fwd_data[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural reg_file model.
module tb_regfile_wb_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][5:0]  req_addr;
  logic [1:0][31:0] req_data;
  logic [5:0]       A3;
  logic [31:0]      WD3;
  logic             WEN;
  logic [5:0]       rd_addr1, rd_addr2;
  logic             fwd_hit1, fwd_hit2;
  logic [31:0]      fwd_data1, fwd_data2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [64];

  regfile_wb_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .A3(A3), .WD3(WD3), .WEN(WEN),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (WEN) rf[A3] <= WD3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    rd_addr1 = 6'd5;
    rd_addr2 = 6'd7;
    step();
    step();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", WEN); end
    n_checks++; if (A3 !== 6'd0) begin n_fail++; $display("FAIL reset_a3 got %0d want 0", A3); end
    n_checks++; if (WD3 !== 32'd0) begin n_fail++; $display("FAIL reset_wd3 got %h want 0", WD3); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready); end
    n_checks++; if ({fwd_hit1, fwd_hit2} !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_hit got %b want 00", {fwd_hit1, fwd_hit2}); end
    n_checks++; if (fwd_data1 !== 32'd0 || fwd_data2 !== 32'd0) begin n_fail++; $display("FAIL reset_fwd_data got %h/%h want 0/0", fwd_data1, fwd_data2); end
    reset = 1'b1;
    step();
    n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL reset_release_ready got %b want 11", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 2'b01;
    req_addr[0] = 6'd5;
    req_data[0] = 32'hDEADBEEF;
    rd_addr1 = 6'd5;
    #1;
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", req_ready[0]); end
    step();
    idle_inputs();
    n_checks++; if (WEN !== 1'b1 || A3 !== 6'd5 || WD3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write got wen=%b a3=%0d wd3=%h want 1/5/deadbeef", WEN, A3, WD3); end
    n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_fwd got %b/%h want 1/deadbeef", fwd_hit1, fwd_data1); end
    step();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL single_idle_wen got %b want 0", WEN); end
    n_checks++; if (rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf got %h want deadbeef", rf[5]); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] first_a [2];
    logic [5:0] second_a [2];
    first_a[0] = 6'd3; second_a[0] = 6'd7;
    first_a[1] = 6'd7; second_a[1] = 6'd3;
    for (int r = 0; r < 2; r++) begin
      req_valid = 2'b11;
      req_addr[0] = 6'd3; req_data[0] = 32'd3;
      req_addr[1] = 6'd7; req_data[1] = 32'd7;
      #1;
      n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL simul_ready_in round %0d got %b want 11", r, req_ready); end
      step();
      idle_inputs();
      n_checks++; if (WEN !== 1'b1 || A3 !== first_a[r] || WD3 !== 32'(first_a[r])) begin n_fail++; $display("FAIL simul_first round %0d got wen=%b a3=%0d wd3=%0d want 1/%0d", r, WEN, A3, WD3, first_a[r]); end
      if (r == 0) begin
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL simul_ready_busy got %b want 01", req_ready); end
      end
      step();
      n_checks++; if (WEN !== 1'b1 || A3 !== second_a[r] || WD3 !== 32'(second_a[r])) begin n_fail++; $display("FAIL simul_second round %0d got wen=%b a3=%0d wd3=%0d want 1/%0d", r, WEN, A3, WD3, second_a[r]); end
      step();
      n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL simul_drained round %0d got %b want 0", r, WEN); end
    end
  endtask

  task automatic test_waw();
    req_valid = 2'b11;
    req_addr[0] = 6'd9; req_data[0] = 32'd1;
    req_addr[1] = 6'd9; req_data[1] = 32'd2;
    rd_addr1 = 6'd9;
    step();
    idle_inputs();
    n_checks++; if (WEN !== 1'b1 || A3 !== 6'd9 || WD3 !== 32'd1) begin n_fail++; $display("FAIL waw_first got wen=%b a3=%0d wd3=%0d want 1/9/1", WEN, A3, WD3); end
    n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd2) begin n_fail++; $display("FAIL waw_fwd_both got %b/%0d want 1/2", fwd_hit1, fwd_data1); end
    step();
    n_checks++; if (WEN !== 1'b1 || A3 !== 6'd9 || WD3 !== 32'd2) begin n_fail++; $display("FAIL waw_second got wen=%b a3=%0d wd3=%0d want 1/9/2", WEN, A3, WD3); end
    n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd2) begin n_fail++; $display("FAIL waw_fwd_one got %b/%0d want 1/2", fwd_hit1, fwd_data1); end
    step();
    n_checks++; if (WEN !== 1'b0 || fwd_hit1 !== 1'b0) begin n_fail++; $display("FAIL waw_drained got wen=%b hit=%b want 0/0", WEN, fwd_hit1); end
    n_checks++; if (rf[9] !== 32'd2) begin n_fail++; $display("FAIL waw_rf got %0d want 2", rf[9]); end
  endtask

  task automatic test_discard();
    req_valid = 2'b10;
    req_addr[1] = 6'd0;
    req_data[1] = 32'hFFFF_FFFF;
    rd_addr1 = 6'd0;
    #1;
    n_checks++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL discard_ready got %b want 1", req_ready[1]); end
    step();
    idle_inputs();
    n_checks++; if (WEN !== 1'b0 || fwd_hit1 !== 1'b0) begin n_fail++; $display("FAIL discard_nowrite got wen=%b hit=%b want 0/0", WEN, fwd_hit1); end
    step();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL discard_later got %b want 0", WEN); end
  endtask

  task automatic test_streaming();
    int k0 = 0, k1 = 0, e0 = 0, e1 = 0, writes = 0, lw = -1;
    int who;
    logic [1:0] hs;
    for (int c = 0; c < 40; c++) begin
      if (WEN) begin
        who = (A3 >= 6'd32) ? 1 : 0;
        writes++;
        n_checks++;
        if (who == 0 && (A3 !== 6'(8 + e0) || WD3 !== 32'hA000_0000 + 32'(e0))) begin
          n_fail++; $display("FAIL stream_data0 got a3=%0d wd3=%h want %0d/%h", A3, WD3, 8 + e0, 32'hA000_0000 + 32'(e0));
        end else if (who == 1 && (A3 !== 6'(32 + e1) || WD3 !== 32'hB000_0000 + 32'(e1))) begin
          n_fail++; $display("FAIL stream_data1 got a3=%0d wd3=%h want %0d/%h", A3, WD3, 32 + e1, 32'hB000_0000 + 32'(e1));
        end
        n_checks++; if (who == lw) begin n_fail++; $display("FAIL stream_alternate got requester %0d twice want alternation", who); end
        if (who == 0) e0++; else e1++;
        lw = who;
      end
      if (c < 20) begin
        req_valid = 2'b11;
        req_addr[0] = 6'(8 + k0);  req_data[0] = 32'hA000_0000 + 32'(k0);
        req_addr[1] = 6'(32 + k1); req_data[1] = 32'hB000_0000 + 32'(k1);
      end else begin
        idle_inputs();
      end
      #1;
      hs = req_valid & req_ready;
      step();
      if (hs[0]) k0++;
      if (hs[1]) k1++;
    end
    n_checks++; if (writes !== k0 + k1 || writes < 20) begin n_fail++; $display("FAIL stream_count got %0d writes want %0d (>=20)", writes, k0 + k1); end
    n_checks++; if (e0 !== k0 || e1 !== k1) begin n_fail++; $display("FAIL stream_per_req got %0d/%0d want %0d/%0d", e0, e1, k0, k1); end
  endtask

  task automatic test_reset_midop();
    req_valid = 2'b11;
    req_addr[0] = 6'd20; req_data[0] = 32'h20;
    req_addr[1] = 6'd21; req_data[1] = 32'h21;
    rd_addr1 = 6'd20;
    rd_addr2 = 6'd21;
    step();
    idle_inputs();
    n_checks++; if ({fwd_hit1, fwd_hit2} !== 2'b11 || WEN !== 1'b1) begin n_fail++; $display("FAIL midop_held got hits=%b wen=%b want 11/1", {fwd_hit1, fwd_hit2}, WEN); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (WEN !== 1'b0 || {fwd_hit1, fwd_hit2} !== 2'b00) begin n_fail++; $display("FAIL midop_async got wen=%b hits=%b want 0/00", WEN, {fwd_hit1, fwd_hit2}); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL midop_ready_low got %b want 00", req_ready); end
    step();
    step();
    reset = 1'b1;
    step();
    n_checks++; if (req_ready !== 2'b11 || WEN !== 1'b0) begin n_fail++; $display("FAIL midop_release got ready=%b wen=%b want 11/0", req_ready, WEN); end
    step();
    n_checks++; if (WEN !== 1'b0) begin n_fail++; $display("FAIL midop_nowrite got %b want 0", WEN); end
    n_checks++; if (rf[20] !== 32'd0 || rf[21] !== 32'd0) begin n_fail++; $display("FAIL midop_rf got %h/%h want 0/0", rf[20], rf[21]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = '0;
    reset = 1'b0;
    idle_inputs();
    rd_addr1 = '0;
    rd_addr2 = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_waw();
    test_discard();
    test_streaming();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
